// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bundle for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] OP_FWD = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: one partial product per step, sequenced by the caller.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] pp;

    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
            assign pp[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    // Product as it will stand once the pending step is applied; after the
    // last step this is the full 2*WIDTH-bit product.
    assign product = acc_reg + pp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{WIDTH{1'b0}}, a};
            mplier_reg <= b;
        end else if (step) begin
            acc_reg    <= product;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; MUL takes WIDTH extra cycles.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       select,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative,
    output logic             busy
);

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] result_reg, result_next;
    flags_t           flags_reg, flags_next;
    logic [SHW-1:0]   cnt_reg, cnt_next;
    logic             mul_load, mul_step;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0] alu_res;
    logic             alu_carry, alu_ovf;
    logic [WIDTH:0]   sum_ext, diff_ext, sll_ext, sra_ext;
    logic signed [WIDTH:0] sra_in;
    logic [SHW-1:0]   amt;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (mul_load),
        .step    (mul_step),
        .a       (data1),
        .b       (data2),
        .product (product)
    );

    // Shifts run one bit wider so the last bit shifted out lands in the
    // extra bit; an amount of zero therefore yields carry 0 naturally.
    assign amt      = data2[SHW-1:0];
    assign sum_ext  = {1'b0, data1} + {1'b0, data2};
    assign diff_ext = {1'b0, data1} - {1'b0, data2};
    assign sll_ext  = {1'b0, data1} << amt;
    assign sra_in   = {data1, 1'b0};
    assign sra_ext  = sra_in >>> amt;

    always_comb begin
        alu_res   = data2;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (select)
            OP_FWD: alu_res = data2;
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (data1[WIDTH-1] == data2[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_AND: alu_res = data1 & data2;
            OP_OR:  alu_res = data1 | data2;
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (data1[WIDTH-1] != data2[WIDTH-1]) &&
                            (diff_ext[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SLL: begin
                alu_res   = sll_ext[WIDTH-1:0];
                alu_carry = sll_ext[WIDTH];
            end
            OP_SRA: begin
                alu_res   = sra_ext[WIDTH:1];
                alu_carry = sra_ext[0];
            end
            default: alu_res = data2;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        flags_next  = flags_reg;
        cnt_next    = cnt_reg;
        mul_load    = 1'b0;
        mul_step    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    if (select == OP_MUL) begin
                        mul_load   = 1'b1;
                        cnt_next   = '0;
                        state_next = MUL;
                    end else begin
                        result_next = alu_res;
                        flags_next  = '{zero: (alu_res == '0), carry: alu_carry,
                                        overflow: alu_ovf, negative: alu_res[WIDTH-1]};
                        state_next  = DONE;
                    end
                end
            end
            MUL: begin
                mul_step = 1'b1;
                cnt_next = cnt_reg + SHW'(1);
                if (cnt_reg == LAST_STEP) begin
                    result_next = product[WIDTH-1:0];
                    flags_next  = '{zero: (product[WIDTH-1:0] == '0),
                                    carry: (product[2*WIDTH-1:WIDTH] != '0),
                                    overflow: 1'b0, negative: product[WIDTH-1]};
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign in_ready  = reset_n && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == MUL);
    assign result    = result_reg;
    assign zero      = flags_reg.zero;
    assign carry     = flags_reg.carry;
    assign overflow  = flags_reg.overflow;
    assign negative  = flags_reg.negative;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector table plus backpressure and mid-MUL reset sequences.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] select = 3'd0;
    logic [7:0] data1 = 8'h00;
    logic [7:0] data2 = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       zero, carry, overflow, negative, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .data1     (data1),
        .data2     (data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative),
        .busy      (busy)
    );

    typedef struct {
        logic [2:0] sel;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] res;
        logic [3:0] flg;   // {zero, carry, overflow, negative}
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns once it has been accepted.
    task automatic issue(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        select   = s;
        data1    = a;
        data2    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data1    = 8'hEE;
        data2    = 8'hEE;
    endtask

    // Sampled just after the accept edge: latency counts cycles until out_valid.
    task automatic wait_out(output int lat, output int busy_cnt);
        lat = 1;
        busy_cnt = 0;
        while (!out_valid && lat < 30) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_out_valid", {31'd0, out_valid}, 32'd0);
        check("retire_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat, bcnt, vseen;

        vecs[0]  = '{3'd0, 8'h12, 8'hA5, 8'hA5, 4'b0001};
        vecs[1]  = '{3'd1, 8'hFF, 8'h01, 8'h00, 4'b1100};
        vecs[2]  = '{3'd1, 8'h7F, 8'h01, 8'h80, 4'b0011};
        vecs[3]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000};
        vecs[4]  = '{3'd3, 8'h00, 8'h00, 8'h00, 4'b1000};
        vecs[5]  = '{3'd4, 8'h80, 8'h01, 8'h7F, 4'b0010};
        vecs[6]  = '{3'd4, 8'h01, 8'h02, 8'hFF, 4'b0101};
        vecs[7]  = '{3'd5, 8'h10, 8'h11, 8'h10, 4'b0100};
        vecs[8]  = '{3'd5, 8'h0F, 8'h0D, 8'hC3, 4'b0001};
        vecs[9]  = '{3'd6, 8'h81, 8'h01, 8'h02, 4'b0100};
        vecs[10] = '{3'd7, 8'h90, 8'h03, 8'hF2, 4'b0001};
        vecs[11] = '{3'd6, 8'h81, 8'h09, 8'h02, 4'b0100};
        vecs[12] = '{3'd6, 8'h81, 8'h00, 8'h81, 4'b0001};
        vecs[13] = '{3'd7, 8'h90, 8'h08, 8'h90, 4'b0001};
        vecs[14] = '{3'd7, 8'h55, 8'h01, 8'h2A, 4'b0100};

        // Reset state
        #12;
        check("rst_outputs", {24'd0, out_valid, busy, zero, carry, overflow, negative, 2'b00}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].sel, vecs[i].d1, vecs[i].d2);
            wait_out(lat, bcnt);
            check("latency", lat, (vecs[i].sel == 3'd5) ? 32'd9 : 32'd1);
            check("busy_cycles", bcnt, (vecs[i].sel == 3'd5) ? 32'd8 : 32'd0);
            check("result", {24'd0, result}, {24'd0, vecs[i].res});
            check("flags", {28'd0, zero, carry, overflow, negative}, {28'd0, vecs[i].flg});
            $display("vec %0d sel %0d d1 %h d2 %h -> result %h flags %b latency %0d",
                     i, vecs[i].sel, vecs[i].d1, vecs[i].d2, result,
                     {zero, carry, overflow, negative}, lat);
            retire();
        end

        // Backpressure: result held, new request ignored while DONE
        issue(3'd1, 8'h03, 8'h04);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        select   = 3'd4;
        data1    = 8'h55;
        data2    = 8'h11;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_hold", {22'd0, out_valid, in_ready, result}, {22'd0, 1'b1, 1'b0, 8'h07});
        end
        in_valid = 1'b0;
        retire();
        check("bp_result_kept", {24'd0, result}, 32'h07);
        $display("backpressure ADD 03+04 -> result %h", result);

        // Reset three cycles into a MUL
        issue(3'd5, 8'h10, 8'h11);
        tick();
        tick();
        check("mid_mul_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rst", {23'd0, out_valid, busy, zero, carry, overflow, negative, in_ready, 2'b00},
              32'd0);
        check("async_rst_result", {24'd0, result}, 32'd0);
        tick();
        tick();
        tick();
        reset_n = 1'b1;
        vseen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (out_valid || busy) vseen++;
        end
        check("no_valid_after_rst", vseen, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        issue(3'd1, 8'h01, 8'h01);
        wait_out(lat, bcnt);
        check("post_rst_latency", lat, 32'd1);
        check("post_rst_add", {24'd0, result}, 32'h02);
        $display("post-reset ADD 01+01 -> result %h", result);
        retire();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
